// File: rtl/captura_digitos_if.sv
// Keypad-to-collector bus: key events in, completed digit words out.
interface captura_digitos_if;
    localparam int unsigned KEY_W  = 4;
    localparam int unsigned WORD_W = 80;

    logic              enable;
    logic              key_valid;
    logic [KEY_W-1:0]  key_code;
    logic [WORD_W-1:0] digitos_value;
    logic              digitos_valid;

    // Keypad side: drives key events and enable, consumes emitted words.
    modport master (
        output enable,
        output key_valid,
        output key_code,
        input  digitos_value,
        input  digitos_valid
    );

    // Collector side.
    modport slave (
        input  enable,
        input  key_valid,
        input  key_code,
        output digitos_value,
        output digitos_valid
    );
endinterface

// File: rtl/captura_digitos.sv
// Keypad digit collector: accumulates up to 20 decimal digits and emits one
// word with a single-cycle valid pulse on confirm, abort or inactivity timeout.
module captura_digitos #(
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic               clk,
    input  logic               rst,
    captura_digitos_if.slave   bus
);
    localparam int unsigned NDIG   = 20;
    localparam int unsigned DW     = 4;
    localparam int unsigned WORD_W = NDIG * DW;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WORD_W-1:0] ALL_F = {NDIG{4'hF}};
    localparam logic [WORD_W-1:0] ALL_B = {NDIG{4'hB}};
    localparam logic [WORD_W-1:0] ALL_E = {NDIG{4'hE}};

    localparam logic [DW-1:0] KEY_ABORT   = 4'hA;
    localparam logic [DW-1:0] KEY_CONFIRM = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [WORD_W-1:0]  value_q, value_d;
    logic               valid_q, valid_d;
    logic [WORD_W-1:0]  emit_word;

    logic is_digit, is_abort, is_confirm;

    assign is_digit   = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_abort   = bus.key_valid && (bus.key_code == KEY_ABORT);
    assign is_confirm = bus.key_valid && (bus.key_code == KEY_CONFIRM);

    // Next-state, buffer update and next output word.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        tmr_d     = '0;
        emit_word = ALL_F;

        case (state_q)
            ST_IDLE: begin
                if (is_digit) begin
                    buf_d   = {buf_q[WORD_W-DW-1:0], bus.key_code};
                    cnt_d   = CNT_W'(1);
                    state_d = ST_ENTRY;
                end else if (is_confirm) begin
                    emit_word = ALL_F;
                    state_d   = ST_EMIT;
                end else if (is_abort) begin
                    emit_word = ALL_B;
                    state_d   = ST_EMIT;
                end
            end
            ST_ENTRY: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (is_digit) begin
                    buf_d = {buf_q[WORD_W-DW-1:0], bus.key_code};
                    cnt_d = (cnt_q == CNT_W'(NDIG)) ? cnt_q : cnt_q + CNT_W'(1);
                    tmr_d = '0;
                end else if (is_confirm) begin
                    emit_word = buf_q;
                    state_d   = ST_EMIT;
                end else if (is_abort) begin
                    emit_word = ALL_B;
                    state_d   = ST_EMIT;
                end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    emit_word = ALL_E;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Entering or sitting in EMIT clears the working storage.
        if (state_d == ST_EMIT || state_q == ST_EMIT) begin
            buf_d = ALL_F;
            cnt_d = '0;
            tmr_d = '0;
        end

        if (!bus.enable) begin
            state_d = ST_IDLE;
            buf_d   = ALL_F;
            cnt_d   = '0;
            tmr_d   = '0;
        end

        valid_d = (state_d == ST_EMIT);
        value_d = valid_d ? emit_word : buf_d;
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            buf_q   <= ALL_F;
            cnt_q   <= '0;
            tmr_q   <= '0;
            value_q <= ALL_F;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

    assign bus.digitos_value = value_q;
    assign bus.digitos_valid = valid_q;
endmodule

// File: tb/tb_captura_digitos.sv
// Directed bench for captura_digitos with a short inactivity timeout.
module tb_captura_digitos;
    localparam int unsigned T = 10;
    localparam logic [79:0] ALL_F = {20{4'hF}};
    localparam logic [79:0] ALL_B = {20{4'hB}};
    localparam logic [79:0] ALL_E = {20{4'hE}};

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    captura_digitos_if bus ();

    captura_digitos #(.TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if it differs.
    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] push(input logic [79:0] w, input logic [3:0] d);
        return {w[75:0], d};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a key for one cycle; returns at the negedge where its effect is visible.
    task automatic press(input logic [3:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    logic [79:0] exp_w;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst           = 1'b0;
        bus.enable    = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        step(3);
        rst = 1'b1;
        step(1);
        check_eq("reset_value", bus.digitos_value, ALL_F);
        check_eq("reset_valid", 80'(bus.digitos_valid), 80'(0));

        // Two-digit entry then confirm.
        exp_w = push(push(ALL_F, 4'h3), 4'h5);
        press(4'h3);
        check_eq("echo_3", bus.digitos_value, push(ALL_F, 4'h3));
        press(4'h5);
        check_eq("echo_35", bus.digitos_value, exp_w);
        press(4'hB);
        check_eq("confirm_valid", 80'(bus.digitos_valid), 80'(1));
        check_eq("confirm_value", bus.digitos_value, exp_w);
        step(1);
        check_eq("after_emit_valid", 80'(bus.digitos_valid), 80'(0));
        check_eq("after_emit_value", bus.digitos_value, ALL_F);

        // Bare confirm gives the skip code.
        press(4'hB);
        check_eq("skip_valid", 80'(bus.digitos_valid), 80'(1));
        check_eq("skip_value", bus.digitos_value, ALL_F);
        step(1);

        // Abort after digits gives the exit code.
        press(4'h1);
        press(4'h2);
        press(4'hA);
        check_eq("abort_valid", 80'(bus.digitos_valid), 80'(1));
        check_eq("abort_value", bus.digitos_value, ALL_B);
        step(1);

        // Ignored code in IDLE and in ENTRY.
        press(4'hC);
        check_eq("ign_idle_value", bus.digitos_value, ALL_F);
        check_eq("ign_idle_valid", 80'(bus.digitos_valid), 80'(0));
        press(4'h6);
        press(4'hD);
        check_eq("ign_entry_value", bus.digitos_value, push(ALL_F, 4'h6));
        press(4'hA);
        step(1);

        // Timeout: pulse exactly T+1 cycles after the last digit.
        press(4'h7);
        for (int i = 0; i < 10; i++) begin
            check_eq("to_quiet", 80'(bus.digitos_valid), 80'(0));
            step(1);
        end
        check_eq("to_valid", 80'(bus.digitos_valid), 80'(1));
        check_eq("to_value", bus.digitos_value, ALL_E);
        step(1);
        check_eq("to_after_value", bus.digitos_value, ALL_F);

        // A digit at cycle 9 restarts the timer.
        press(4'h7);
        step(8);
        press(4'h8);
        for (int i = 0; i < 10; i++) begin
            check_eq("to_restart_quiet", 80'(bus.digitos_valid), 80'(0));
            step(1);
        end
        check_eq("to_restart_valid", 80'(bus.digitos_valid), 80'(1));
        check_eq("to_restart_value", bus.digitos_value, ALL_E);
        step(1);

        // Overflow: 22 digits, the oldest two fall off.
        for (int j = 0; j < 22; j++) press(4'(j % 10));
        for (int k = 0; k < 20; k++) exp_w[4*k +: 4] = 4'((21 - k) % 10);
        check_eq("ovf_buffer", bus.digitos_value, exp_w);
        press(4'hB);
        check_eq("ovf_valid", 80'(bus.digitos_valid), 80'(1));
        check_eq("ovf_value", bus.digitos_value, exp_w);
        check_eq("ovf_d0", 80'(bus.digitos_value[3:0]), 80'(1));
        check_eq("ovf_d19", 80'(bus.digitos_value[79:76]), 80'(2));
        step(1);

        // Enable low discards the entry without a pulse.
        press(4'h4);
        press(4'h4);
        check_eq("en_buffer", bus.digitos_value, push(push(ALL_F, 4'h4), 4'h4));
        bus.enable = 1'b0;
        step(1);
        check_eq("en_off_value", bus.digitos_value, ALL_F);
        check_eq("en_off_valid", 80'(bus.digitos_valid), 80'(0));
        press(4'hB);
        check_eq("en_off_confirm", 80'(bus.digitos_valid), 80'(0));
        bus.enable = 1'b1;
        step(1);

        // Key landing in the EMIT cycle is dropped.
        press(4'h9);
        press(4'hB);
        check_eq("drop_valid", 80'(bus.digitos_valid), 80'(1));
        check_eq("drop_value", bus.digitos_value, push(ALL_F, 4'h9));
        press(4'h2);
        check_eq("drop_idle_value", bus.digitos_value, ALL_F);
        check_eq("drop_idle_valid", 80'(bus.digitos_valid), 80'(0));
        step(1);
        check_eq("drop_idle_value2", bus.digitos_value, ALL_F);

        // Reset during ENTRY discards the entry.
        press(4'h6);
        rst = 1'b0;
        step(1);
        check_eq("rst_entry_value", bus.digitos_value, ALL_F);
        check_eq("rst_entry_valid", 80'(bus.digitos_valid), 80'(0));
        rst = 1'b1;
        step(1);

        // Reset in the EMIT cycle keeps the pulse already present.
        press(4'h1);
        press(4'hB);
        rst = 1'b0;
        check_eq("rst_emit_valid", 80'(bus.digitos_valid), 80'(1));
        check_eq("rst_emit_value", bus.digitos_value, push(ALL_F, 4'h1));
        step(1);
        check_eq("rst_emit_after_valid", 80'(bus.digitos_valid), 80'(0));
        check_eq("rst_emit_after_value", bus.digitos_value, ALL_F);
        rst = 1'b1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/captura_digitos.md
# captura_digitos

Keypad digit collector feeding the `setup` stage and the other digit consumers in the lock. It takes single-cycle key events from the keypad decoder, accumulates decimal digits into a 20-digit `senhaPac_t` word, and on confirm, abort or inactivity timeout emits one word with a one-cycle `digitos_valid` pulse. Between pulses, `digitos_value` continuously mirrors the in-progress buffer so downstream display logic can echo typed digits live.

## Interface
- `TIMEOUT_CYCLES`, default 250_000_000: inactivity limit in clock cycles (5 s at 50 MHz). The bench overrides it with a small value.
- `clk` input 1: system clock. All logic on the rising edge.
- `rst` input 1: reset. **Synchronous and active-low**: sampled on `clk`, reset when 0.
- `enable` input 1: collector active. When low, the buffer is held cleared and nothing is emitted.
- `key_valid` input 1: one-cycle pulse, `key_code` is valid this cycle.
- `key_code` input 4: 0–9 = digit, 4'hA = `*` (abort), 4'hB = `#` (confirm), 4'hC–4'hF = ignored.
- `digitos_value` output 80: `senhaPac_t`, `digits[19:0]` × 4 bits. `digits[0]` is the most recently typed digit; unused slots hold 4'hF.
- `digitos_valid` output 1: one-cycle pulse qualifying `digitos_value` as a completed entry.

## Operation
- **Storage**
  - 20×4 shift buffer `buf`.
  - Digit count `cnt` (0..20, saturating).
  - Timeout counter `tmr`, `$clog2(TIMEOUT_CYCLES+1)` bits.
- **States**
  - **IDLE** (buffer empty, `cnt`=0): a digit shifts in → ENTRY. `#` → EMIT with all-F (skip code). `*` → EMIT with all-B (exit code).
  - **ENTRY** (`cnt`>0):
    - A digit shifts in: `buf[i+1]<=buf[i]`, `buf[0]<=key`, `buf[19]` is dropped, `cnt` saturates at 20, `tmr` clears.
    - `#` → EMIT with `buf`.
    - `*` → EMIT with all-B; the partial entry is discarded.
    - `tmr` reaches `TIMEOUT_CYCLES`-1 → EMIT with all-E (timeout code).
  - **EMIT**: `digitos_valid`=1 and `digitos_value`=the emitted word for exactly this cycle. `buf`, `cnt` and `tmr` clear. Next state is IDLE unconditionally.
- **Output value outside EMIT**: `digitos_value` = `buf`. This is all-F in IDLE.
- **Ignored keys**: codes C–F are ignored in every state. `key_valid` in EMIT is dropped, whatever the code.
- **Timer**: `tmr` increments every cycle in ENTRY only. It is held at 0 in IDLE and EMIT. No timeout fires from IDLE.
- **`enable` low** in any state: next state IDLE, buffer cleared, no pulse, `tmr`=0.
  - If `enable` falls in the EMIT cycle, the pulse in that cycle still completes.
- **Simultaneous events in ENTRY**: a key event takes priority over a timeout expiring in the same cycle. A digit restarts the timer; `#` or `*` emit their own word.
- **Invariant**: the emitted all-F, all-B and all-E codes never coincide with a real entry, because a real entry always has `digits[0]` in 0–9.

## Timing
- **Reset values**: `digitos_value`=all-F, `digitos_valid`=0, state IDLE, `cnt`=0, `tmr`=0.
- **Reset mid-operation**:
  - Reset during ENTRY discards the entry with no pulse.
  - Reset asserted in the EMIT cycle does not suppress the pulse already present, but the next cycle's outputs are the reset values.
- **Digit echo latency**: a digit on `key_valid` in cycle N is visible in `digitos_value.digits[0]` in cycle N+1.
- **Confirm/abort latency**: `#` or `*` in cycle N gives `digitos_valid`=1 in cycle N+1 and `digitos_value`=all-F in cycle N+2.
- **Timeout latency**: with the last digit in cycle N, `digitos_valid` rises in cycle N+`TIMEOUT_CYCLES`+1.
- **Throughput**: back-to-back key pulses on consecutive cycles are all accepted, except the one landing in the EMIT cycle.
- **Consumer contract**: no handshake. The consumer must sample on the pulse.

## Test plan
- **Reset**: hold `rst`=0 for 3 cycles, release → `digitos_value`=all-F, `digitos_valid`=0.
- **Two-digit entry**: keys 3, 5, `#` → after the 5, `digits[1:0]`={3,5}; pulse with `digits[1:0]`={3,5} and `digits[19:2]` all F; next cycle all-F.
- **Bare keys**:
  - `#` with empty buffer → pulse with all-F.
  - `*` after digits 1, 2 → pulse with all-B.
  - Key C → no change.
- **Timeout**: `TIMEOUT_CYCLES`=10, key 7, then idle.
  - Pulse with all-E exactly 11 cycles after the 7.
  - A digit at cycle 9 restarts the count.
- **Overflow**: 22 digits 0,1,…,9,0,1,…,9,0,1 then `#` → `digits[0]`=1, `digits[19]`=2 (the first two digits dropped).
- **Enable/reset disruption and EMIT drop**:
  - Digits 4, 4, then `enable`=0 → buffer all-F, no pulse.
  - Digits 9, `#`, then key 2 in the EMIT cycle → the 2 is dropped; the following IDLE buffer is all-F.
